// File: rtl/rng_pkg.sv
// Shared types and default sizes for the random-bit word packer.
package rng_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } rng_state_e;

  localparam int unsigned RNG_WORD_W = 32;
  localparam int unsigned RNG_DROP_W = 16;

endpackage

// File: rtl/rng_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module rng_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rng_word_packer.sv
// Packs de-biased random bits LSB-first into words, presents them on a
// ready/valid output and pauses the bit source while a finished word waits.
module rng_word_packer
  import rng_pkg::*;
#(
  parameter int unsigned WORD_W = RNG_WORD_W,
  parameter int unsigned DROP_W = RNG_DROP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              bit_valid,
  input  logic              bit_data,
  output logic              db_enable,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);

  rng_state_e        state_d, state_q;
  logic [WORD_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              word_valid_d, word_valid_q;
  logic [WORD_W-1:0] word_data_d, word_data_q;
  logic              drain;
  logic              drop_inc;

  assign drain    = word_valid_q && word_ready;
  assign drop_inc = (state_q == STALL) && en && bit_valid;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;

    // A load below re-asserts valid, giving back-to-back words.
    if (drain) begin
      word_valid_d = 1'b0;
    end

    unique case (state_q)
      FILL: begin
        if (en && bit_valid) begin
          acc_d = {bit_data, acc_q[WORD_W-1:1]};
          if (cnt_q == CNT_LAST) begin
            if (!word_valid_q || drain) begin
              word_data_d  = acc_d;
              word_valid_d = 1'b1;
              cnt_d        = '0;
            end else begin
              state_d = STALL;
              cnt_d   = CNT_FULL;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      STALL: begin
        if (drain) begin
          word_data_d  = acc_q;
          word_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      acc_q        <= '0;
      cnt_q        <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
    end
  end

  rng_sat_counter #(
    .W(DROP_W)
  ) u_drop_cnt (
    .clk(clk),
    .clr(rst),
    .inc(drop_inc),
    .cnt(drop_cnt)
  );

  assign db_enable  = en && !rst && (state_q == FILL);
  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign busy       = (cnt_q != '0) || (state_q == STALL);

endmodule

// File: tb/tb_rng_word_packer.sv
// Directed bench for rng_word_packer with an 8-bit word and 4-bit drop counter.
module tb_rng_word_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       bit_valid;
  logic       bit_data;
  logic       db_enable;
  logic       word_valid;
  logic       word_ready;
  logic [7:0] word_data;
  logic       busy;
  logic [3:0] drop_cnt;

  int unsigned total = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  rng_word_packer #(
    .WORD_W(8),
    .DROP_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .bit_valid(bit_valid),
    .bit_data(bit_data),
    .db_enable(db_enable),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_data(word_data),
    .busy(busy),
    .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change only just after a falling edge; outputs are read there too.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_data  = b[i];
      tick();
    end
    bit_valid = 1'b0;
    bit_data  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; bit_valid = 1'b0; bit_data = 1'b0; word_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", word_valid, 0);
    chk("rst_data", word_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_db_en", db_enable, 0);
    rst = 1'b0;
    tick();
    chk("db_en_after_rst", db_enable, 1);

    // Basic word: bits 1,0,1,1,0,0,1,0 -> 8'h4D.
    send_bits(8'h4D, 7);
    chk("t1_valid_7", word_valid, 0);
    chk("t1_busy_7", busy, 1);
    send_bits(8'h01 >> 1, 1);
    chk("t1_valid", word_valid, 1);
    chk("t1_data", word_data, 8'h4D);
    chk("t1_busy", busy, 0);
    chk("t1_drop", drop_cnt, 0);
    tick();
    chk("t1_drained", word_valid, 0);

    // Stall: 16 ones with no ready, then 3 dropped bits.
    do_reset();
    word_ready = 1'b0;
    send_bits(8'hFF, 8);
    chk("t2_first_valid", word_valid, 1);
    chk("t2_first_data", word_data, 8'hFF);
    send_bits(8'hFF, 8);
    chk("t2_stall_db_en", db_enable, 0);
    chk("t2_stall_busy", busy, 1);
    chk("t2_held_data", word_data, 8'hFF);
    send_bits(8'h05, 3);
    chk("t2_drop3", drop_cnt, 3);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("t2_second_valid", word_valid, 1);
    chk("t2_second_data", word_data, 8'hFF);
    chk("t2_db_en_back", db_enable, 1);
    chk("t2_busy_clear", busy, 0);
    chk("t2_drop_kept", drop_cnt, 3);

    // Back-to-back: 8'hA5 waits, 8'h3C completes in the draining cycle.
    do_reset();
    word_ready = 1'b0;
    send_bits(8'hA5, 8);
    chk("t3_a_data", word_data, 8'hA5);
    send_bits(8'h3C, 7);
    chk("t3_a_still_valid", word_valid, 1);
    chk("t3_a_still_data", word_data, 8'hA5);
    word_ready = 1'b1;
    send_bits(8'h3C >> 7, 1);
    chk("t3_b2b_valid", word_valid, 1);
    chk("t3_b2b_data", word_data, 8'h3C);
    chk("t3_b2b_busy", busy, 0);
    tick();
    chk("t3_final_drain", word_valid, 0);

    // en low mid-word retains the partial word (8'h96 split 5 + 3).
    do_reset();
    word_ready = 1'b1;
    send_bits(8'h96, 5);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bit_valid = i[0];
      bit_data  = ~i[1];
      tick();
    end
    chk("t4_db_en_low", db_enable, 0);
    chk("t4_busy", busy, 1);
    chk("t4_drop", drop_cnt, 0);
    chk("t4_no_word", word_valid, 0);
    bit_valid = 1'b0;
    en = 1'b1;
    send_bits(8'h96 >> 5, 2);
    chk("t4_not_yet", word_valid, 0);
    send_bits(8'h96 >> 7, 1);
    chk("t4_valid", word_valid, 1);
    chk("t4_data", word_data, 8'h96);

    // Drop counter saturation at 4'hF.
    do_reset();
    word_ready = 1'b0;
    send_bits(8'hFF, 8);
    send_bits(8'hFF, 8);
    for (int i = 0; i < 15; i++) begin
      bit_valid = 1'b1;
      bit_data  = i[0];
      tick();
    end
    chk("t5_drop15", drop_cnt, 4'hF);
    send_bits(8'h0F, 5);
    chk("t5_drop_sat", drop_cnt, 4'hF);
    chk("t5_still_stall", db_enable, 0);

    // Reset while stalled with a word pending.
    chk("t6_pre_valid", word_valid, 1);
    rst = 1'b1;
    tick();
    chk("t6_valid", word_valid, 0);
    chk("t6_data", word_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_drop", drop_cnt, 0);
    rst = 1'b0;
    tick();
    chk("t6_fill_db_en", db_enable, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rng_word_packer.md
Name: rng_word_packer

Overview:
- Consumer end of the de-biased random bit stream: accepts single-bit valid/data strobes from the de-biaser and packs them into WORD_W-bit words.
- Presents completed words on a ready/valid output handshake to the downstream RNG consumer (seed register, FIFO or bus slave).
- Drives the de-biaser enable so that the bit source pauses cleanly when the packer is stalled.
- Counts bits lost to back-pressure.

Parameters:
- WORD_W, 32, output word width in bits; legal range 2..64.
- DROP_W, 16, width of the saturating dropped-bit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  packer enable; when low, incoming bits are ignored
- bit_valid  in  1  de-biased bit strobe, one cycle per bit
- bit_data  in  1  de-biased bit value, sampled when bit_valid=1
- db_enable  out  1  enable to the de-biaser; equals en AND NOT stalled
- word_valid  out  1  output word available
- word_ready  in  1  downstream accepts the word
- word_data  out  WORD_W  packed word; first accepted bit is in bit 0
- busy  out  1  at least one bit is held in the accumulator
- drop_cnt  out  DROP_W  bits discarded while stalled; saturating

Behaviour:
- Single clock, synchronous active-high reset: clk, rst.
- Reset values: word_valid=0, word_data=0, busy=0, drop_cnt=0, db_enable=0, accumulator=0, bit counter=0, state=FILL.
- An accepted bit is one where en=1, bit_valid=1 and state=FILL.
- Accepted bits shift in LSB-first: acc <= {bit_data, acc[WORD_W-1:1]}. After WORD_W accepted bits, the first accepted bit sits in bit 0.
- Bit counter width is clog2(WORD_W+1); it counts accepted bits 0..WORD_W-1.
- States:
  - FILL: accumulating bits.
  - STALL: accumulator holds a complete word but the output register is occupied.
- On the WORD_W-th accepted bit in cycle t:
  - If the output register is free (word_valid=0), or is being drained in cycle t (word_valid=1 and word_ready=1): load the completed word into word_data. word_valid=1 from t+1 (one-cycle latency). Counter is cleared; stay in FILL.
  - Otherwise: the completed word stays in the accumulator, go to STALL, and the counter holds WORD_W.
- Output handshake: word_valid and word_data are held stable until the cycle where word_valid=1 and word_ready=1. word_valid drops at the next edge unless a new word loads in the same cycle; in that case word_valid stays 1 with the new data (back-to-back words).
- STALL:
  - db_enable=0.
  - Every bit_valid=1 with en=1 is dropped, and drop_cnt increments, saturating at 2^DROP_W-1.
  - When the output handshake completes, the accumulator word moves to word_data at the same edge; word_valid stays 1, counter is cleared and state returns to FILL.
  - A bit arriving in that handshake cycle is still dropped and counted.
- en low:
  - A partial word is retained and the counter holds; no bits are accepted and none are counted as drops.
  - db_enable=0; the output handshake continues to operate.
  - When en rises again, accumulation resumes where it stopped.
- busy = (counter != 0) OR (state == STALL).
- word_ready is ignored when word_valid=0.
- Reset mid-word or mid-stall discards all data immediately; the next cycle shows reset values.
- drop_cnt is cleared only by rst.

Decomposition:
- Package rng_pkg holds:
  - state typedef (FILL, STALL);
  - default constants RNG_WORD_W=32 and RNG_DROP_W=16.
- One sub-module, rng_sat_counter: parameterised-width saturating incrementer with synchronous clear; used for drop_cnt.
- Accumulator, counter, FSM and output register stay in rng_word_packer.

Test Plan:
- WORD_W=8, word_ready=1, en=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> word_valid=1 one cycle after the 8th bit, word_data=8'h4D; drop_cnt=0.
- WORD_W=8, word_ready=0, 16 bits all 1, then 3 more bits -> first word 8'hFF held. After bit 16: state STALL, db_enable=0. Those 3 bits give drop_cnt=3. Raising word_ready for one cycle gives a second 8'hFF, word_valid stays 1, and db_enable returns to 1.
- Back-to-back: completion cycle coincides with word_ready=1 while word_valid=1 -> word_valid never drops; new word_data appears at the next edge.
- en dropped after 5 bits for 10 cycles with bit_valid toggling -> counter stays 5, drop_cnt unchanged, db_enable=0. After en returns, 3 more bits complete the word with the correct bit ordering.
- DROP_W=4, stall with 20 dropped bits -> drop_cnt saturates at 4'hF.
- rst asserted in STALL with word_valid=1 -> next cycle word_valid=0, word_data=0, busy=0, drop_cnt=0, state FILL.
